// File: rtl/serial_word_collector_pkg.sv
// Shared definitions for the serial word collector and its upstream load/shift register.
// The {load,shift} control encoding lets a driver of both blocks stay consistent.
package serial_word_collector_pkg;

    // Bit 0 set means shift regardless of load, so 2'b11 also shifts.
    localparam logic [1:0] CTRL_HOLD  = 2'b00;
    localparam logic [1:0] CTRL_SHIFT = 2'b01;
    localparam logic [1:0] CTRL_LOAD  = 2'b10;

endpackage

// File: rtl/serial_word_collector_word_fifo.sv
// Small word FIFO with synchronous reset; when full, a same-edge pop frees room for the push.
module word_fifo
    import serial_word_collector_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Pointers wrap naturally because DEPTH is a power of two.
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/serial_word_collector.sv
// Reassembles an LSB-first serial bit stream into WIDTH-bit words and buffers them
// for a valid/ready consumer, flagging words lost to a full buffer.
module serial_word_collector
    import serial_word_collector_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ser_valid,
    input  logic                       ser_data,
    input  logic                       ser_sync,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic [WIDTH-1:0]           word_data,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic                       overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] idx;
    logic [WIDTH-1:0] assembled;
    logic             push;
    logic [WIDTH-1:0] push_data;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_full;

    assign pop        = word_ready && !fifo_empty;
    assign word_valid = !fifo_empty;
    assign bit_cnt    = bit_cnt_q;
    assign overflow   = overflow_q;

    always_comb begin
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        push_data  = '0;
        idx        = bit_cnt_q;
        assembled  = shreg_q;
        if (ser_valid) begin
            // A sync bit restarts assembly from an empty word at position 0.
            if (ser_sync) begin
                idx       = '0;
                assembled = '0;
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (idx == CNT_W'(i)) begin
                    assembled[i] = ser_data;
                end
            end
            if (idx == CNT_W'(WIDTH - 1)) begin
                push      = 1'b1;
                push_data = assembled;
                bit_cnt_d = '0;
                shreg_d   = '0;
            end else begin
                bit_cnt_d = idx + CNT_W'(1);
                shreg_d   = assembled;
            end
        end
        if (push && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    word_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_word_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .head_data(word_data),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

endmodule

// File: tb/tb_serial_word_collector.sv
// Self-checking bench for serial_word_collector: directed scenarios, an end-to-end run with
// a load/shift register feeding the collector, and randomized traffic against a queue model.
module tb_serial_word_collector;
    import serial_word_collector_pkg::*;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ser_valid = 1'b0;
    logic             ser_data = 1'b0;
    logic             ser_sync = 1'b0;
    logic             word_ready = 1'b0;
    logic             word_valid;
    logic [WIDTH-1:0] word_data;
    logic [2:0]       bit_cnt;
    logic             overflow;

    logic [1:0]       up_ctrl = CTRL_HOLD;
    logic [3:0]       up_load = 4'h0;
    logic [3:0]       up_q = 4'h0;

    int               n_checks = 0;
    int               n_errors = 0;

    logic             m_bits [$];
    logic [WIDTH-1:0] m_fifo [$];
    logic             m_ovf = 1'b0;

    always #5 clk = ~clk;

    // Upstream load/shift register: data_out[0] is the serial bit, shifted out LSB first.
    always_ff @(posedge clk) begin
        if (up_ctrl[0]) begin
            up_q <= {1'b0, up_q[3:1]};
        end else if (up_ctrl == CTRL_LOAD) begin
            up_q <= up_load;
        end
    end

    serial_word_collector #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ser_valid (ser_valid),
        .ser_data  (ser_data),
        .ser_sync  (ser_sync),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .word_data (word_data),
        .bit_cnt   (bit_cnt),
        .overflow  (overflow)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference behaviour for one clock edge, expressed as bit and word queues.
    task automatic modelEdge(input logic r, input logic v, input logic d, input logic s,
                             input logic rdy);
        logic [WIDTH-1:0] w;
        logic             done;
        logic             do_pop;
        done = 1'b0;
        w    = '0;
        if (r) begin
            m_bits.delete();
            m_fifo.delete();
            m_ovf = 1'b0;
            return;
        end
        do_pop = (m_fifo.size() > 0) && rdy;
        if (v) begin
            if (s) m_bits.delete();
            m_bits.push_back(d);
            if (m_bits.size() == WIDTH) begin
                for (int i = 0; i < WIDTH; i++) w[i] = m_bits[i];
                m_bits.delete();
                done = 1'b1;
            end
        end
        if (do_pop) void'(m_fifo.pop_front());
        if (done) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(w);
            else m_ovf = 1'b1;
        end
    endtask

    // Drive one cycle, advance the model on the same edge, then compare all outputs.
    task automatic applyStimulus(input logic r, input logic v, input logic d, input logic s,
                                 input logic rdy);
        rst        = r;
        ser_valid  = v;
        ser_data   = d;
        ser_sync   = s;
        word_ready = rdy;
        @(posedge clk);
        modelEdge(r, v, d, s, rdy);
        #1;
        checkOutput("word_valid", 32'(word_valid), 32'(m_fifo.size() > 0));
        if (m_fifo.size() > 0) checkOutput("word_data", 32'(word_data), 32'(m_fifo[0]));
        checkOutput("bit_cnt", 32'(bit_cnt), 32'(m_bits.size()));
        checkOutput("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic sendWord(input logic [3:0] w, input logic rdy);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, w[i], i == 0, rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    initial begin
        $display("[TB] start");

        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("rst_word_data", 32'(word_data), 32'h0);
        checkOutput("rst_bit_cnt", 32'(bit_cnt), 32'h0);

        // Single word 1,0,1,1 with the consumer always ready
        sendWord(4'b1101, 1'b1);
        checkOutput("t1_word", 32'(word_data), 32'hd);
        checkOutput("t1_valid", 32'(word_valid), 32'h1);
        idle(1, 1'b1);
        checkOutput("t1_one_cycle", 32'(word_valid), 32'h0);

        // Same word with gaps between bits
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(2, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b1);
        checkOutput("t2_hold_cnt", 32'(bit_cnt), 32'h2);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(3, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t2_word", 32'(word_data), 32'hd);
        idle(1, 1'b1);

        // Resync after a partial word
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("t3_cnt_after_sync", 32'(bit_cnt), 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t3_word", 32'(word_data), 32'h4);
        idle(1, 1'b1);
        checkOutput("t3_single", 32'(word_valid), 32'h0);

        // Backpressure: third word dropped
        sendWord(4'h3, 1'b0);
        sendWord(4'h5, 1'b0);
        sendWord(4'h9, 1'b0);
        checkOutput("t4_overflow", 32'(overflow), 32'h1);
        checkOutput("t4_head_a", 32'(word_data), 32'h3);
        idle(1, 1'b1);
        checkOutput("t4_head_b", 32'(word_data), 32'h5);
        idle(1, 1'b1);
        checkOutput("t4_drained", 32'(word_valid), 32'h0);
        checkOutput("t4_sticky", 32'(overflow), 32'h1);

        // Full FIFO with a pop on the completing edge
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sendWord(4'h3, 1'b0);
        sendWord(4'h5, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t5_no_ovf", 32'(overflow), 32'h0);
        checkOutput("t5_head_b", 32'(word_data), 32'h5);
        idle(1, 1'b1);
        checkOutput("t5_head_c", 32'(word_data), 32'h9);
        idle(1, 1'b1);

        // Reset in the middle of a word and with a buffered word
        sendWord(4'h6, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t6_valid", 32'(word_valid), 32'h0);
        checkOutput("t6_cnt", 32'(bit_cnt), 32'h0);
        checkOutput("t6_ovf", 32'(overflow), 32'h0);
        sendWord(4'ha, 1'b0);
        checkOutput("t6_word", 32'(word_data), 32'ha);
        idle(1, 1'b1);

        // End-to-end: the load/shift register loads 4'b1011 and shifts it out
        up_load = 4'b1011;
        up_ctrl = CTRL_LOAD;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        up_ctrl = CTRL_SHIFT;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, up_ctrl[0], up_q[0], i == 0, 1'b0);
        end
        up_ctrl = CTRL_HOLD;
        checkOutput("e2e_word", 32'(word_data), 32'hb);
        idle(1, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 7,
                          1'($urandom), $urandom_range(0, 9) == 0, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
